program_loader: RTL
===================

PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, meaning the instruction memory address width.
REQ-002 SHALL have parameter INSTR_W, default 15, meaning the instruction word width (7-bit opcode plus 8-bit literal).
REQ-003 SHALL use one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port clk, input, 1 bit: the system clock; all state changes on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous active-low reset.
REQ-006 SHALL have port start, input, 1 bit: a single-cycle request to begin a load session.
REQ-007 SHALL have port byte_in, input, 8 bits: the incoming program stream byte.
REQ-008 SHALL have port byte_valid, input, 1 bit: byte_in carries a valid byte.
REQ-009 SHALL have port byte_ready, output, 1 bit: the loader accepts byte_in this cycle.
REQ-010 SHALL have port imem_addr, output, ADDR_W bits: the instruction memory write address.
REQ-011 SHALL have port imem_data, output, INSTR_W bits: the instruction memory write data.
REQ-012 SHALL have port imem_we, output, 1 bit: the instruction memory write strobe, one cycle per word.
REQ-013 SHALL have port cpu_hold, output, 1 bit: holds the CPU (program counter and registers) in reset while high.
REQ-014 SHALL have port done, output, 1 bit: the last load completed with a correct checksum.
REQ-015 SHALL have port err, output, 1 bit: the last load failed (format or checksum).
REQ-016 SHALL have port words_loaded, output, ADDR_W+1 bits: the count of words written in the current or last session.

Function
REQ-017 SHALL transfer a byte only in a cycle where byte_valid and byte_ready are both high at the rising clk edge.
REQ-018 SHALL implement states IDLE, LEN, HI, LO, WRITE, CHK, DONE, ERR.
REQ-019 SHALL drive byte_ready high only in LEN, HI, LO and CHK.
REQ-020 SHALL move from IDLE, DONE or ERR to LEN when start=1, and in the same edge clear done, err, words_loaded, the address counter and the checksum accumulator, and set cpu_hold=1.
REQ-021 SHALL ignore start in LEN, HI, LO, WRITE and CHK.
REQ-022 SHALL, in LEN, latch the accepted byte as word count N, with 0 meaning 256, then go to HI.
REQ-023 SHALL, in HI, check bit 7 of the accepted byte: if it is 1, go to ERR; otherwise latch bits 6:0 as instr[14:8] and go to LO.
REQ-024 SHALL, in LO, latch the accepted byte as instr[7:0] and go to WRITE.
REQ-025 SHALL, in WRITE, hold imem_we=1 for exactly one cycle with imem_addr equal to the current address and imem_data equal to the assembled word; at that edge it SHALL increment the address and words_loaded.
REQ-026 SHALL, after WRITE, go to CHK if words_loaded equals N, else to HI.
REQ-027 SHALL XOR every accepted byte into an 8-bit accumulator, including the LEN byte and all HI/LO bytes but excluding the checksum byte itself.
REQ-028 SHALL, in CHK, compare the accepted byte with the accumulator: on a match go to DONE, on a mismatch go to ERR.
REQ-029 SHALL, in DONE, hold done=1 and cpu_hold=0.
REQ-030 SHALL, in ERR, hold err=1 and cpu_hold=1.
REQ-031 SHALL keep imem_we=0 in every state other than WRITE.
REQ-032 SHALL wrap the address counter modulo 2^ADDR_W; for N=256 the last write is at address 255.
REQ-033 SHALL leave words already written in memory untouched on an error, with no rollback.
REQ-034 SHALL, if byte_valid is low in a byte-accepting state, remain in that state indefinitely with no timeout.

Reset
REQ-035 SHALL, while reset=0, asynchronously force: state IDLE, byte_ready=0, imem_we=0, imem_addr=0, imem_data=0, words_loaded=0, done=0, err=0, cpu_hold=1, accumulator=0.
REQ-036 SHALL, on reset asserted mid-session, abort the session immediately; no further write strobe is issued, and a new start is required after reset release.

Verification
REQ-037 SHALL pass this scenario: start, then stream 02,01,05,02,0A,checksum=0E -> writes 0x105 at address 0 and 0x20A at address 1, words_loaded=2, done=1, cpu_hold=0.
REQ-038 SHALL pass this scenario: the same stream with checksum 0x0F -> both words written, err=1, done=0, cpu_hold=1.
REQ-039 SHALL pass this scenario: start, 01, then HI byte 0x80 -> ERR immediately, no imem_we pulse, words_loaded=0.
REQ-040 SHALL pass this scenario: LEN=00 followed by 256 word pairs and the correct checksum -> 256 writes at addresses 0..255, words_loaded=256, done=1.
REQ-041 SHALL pass this scenario: byte_valid toggled randomly, plus a start pulse mid-session -> identical memory contents and no restart.
REQ-042 SHALL pass this scenario: reset=0 asserted during WRITE -> imem_we drops asynchronously, state IDLE, cpu_hold=1, done=0, err=0.

Source files
------------

// File: rtl/program_loader.sv
// program_loader: receives a framed program byte stream and writes it into
// instruction memory while holding the CPU in reset.
// Frame: LEN (word count, 0 = 256), then HI/LO byte pairs per word
// (HI bit 7 must be 0), then an XOR checksum of every preceding byte.
// Ports:
//   clk, reset (async, active-low)
//   start                      - one-cycle request to begin a load session
//   byte_in, byte_valid        - incoming stream byte and its valid flag
//   byte_ready                 - loader accepts byte_in this cycle
//   imem_addr/imem_data/imem_we - instruction memory write port
//   cpu_hold                   - keeps the CPU in reset while high
//   done / err                 - last load succeeded / failed
//   words_loaded               - words written in the current or last session
module program_loader #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned INSTR_W = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [7:0]         byte_in,
  input  logic               byte_valid,
  output logic               byte_ready,
  output logic [ADDR_W-1:0]  imem_addr,
  output logic [INSTR_W-1:0] imem_data,
  output logic               imem_we,
  output logic               cpu_hold,
  output logic               done,
  output logic               err,
  output logic [ADDR_W:0]    words_loaded
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam int unsigned HI_W  = INSTR_W - 8;

  typedef enum logic [2:0] {
    IDLE, LEN, HI, LO, WRITE, CHK, DONE, ERR
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [CNT_W-1:0]  n_words;
  logic [7:0]        acc;
  logic              accept_c;

  // A byte moves only when both sides agree at the edge.
  assign accept_c = byte_valid && byte_ready;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic; start is only honoured in the resting states.
  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE, ERR: if (start) state_next = LEN;
      LEN:   if (accept_c) state_next = HI;
      HI:    if (accept_c) state_next = byte_in[7] ? ERR : LO;
      LO:    if (accept_c) state_next = WRITE;
      WRITE: state_next = ((words_loaded + CNT_W'(1)) == n_words) ? CHK : HI;
      CHK:   if (accept_c) state_next = (byte_in == acc) ? DONE : ERR;
      default: state_next = IDLE;
    endcase
  end

  // Registered outputs and datapath. byte_ready/imem_we are computed from the
  // next state so they are valid in the same cycle the FSM sits in that state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      byte_ready   <= 1'b0;
      imem_we      <= 1'b0;
      imem_addr    <= '0;
      imem_data    <= '0;
      words_loaded <= '0;
      done         <= 1'b0;
      err          <= 1'b0;
      cpu_hold     <= 1'b1;
      acc          <= '0;
      n_words      <= '0;
    end else begin
      byte_ready <= (state_next == LEN) || (state_next == HI) ||
                    (state_next == LO)  || (state_next == CHK);
      imem_we    <= (state_next == WRITE);
      case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            done         <= 1'b0;
            err          <= 1'b0;
            words_loaded <= '0;
            imem_addr    <= '0;
            acc          <= '0;
            cpu_hold     <= 1'b1;
          end
        end
        LEN: begin
          if (accept_c) begin
            n_words <= (byte_in == 8'd0) ? CNT_W'(256) : CNT_W'(byte_in);
            acc     <= acc ^ byte_in;
          end
        end
        HI: begin
          if (accept_c) begin
            acc <= acc ^ byte_in;
            if (byte_in[7]) begin
              err      <= 1'b1;
              cpu_hold <= 1'b1;
            end else begin
              imem_data[INSTR_W-1:8] <= HI_W'(byte_in[6:0]);
            end
          end
        end
        LO: begin
          if (accept_c) begin
            acc            <= acc ^ byte_in;
            imem_data[7:0] <= byte_in;
          end
        end
        WRITE: begin
          // Address wraps naturally at 2^ADDR_W.
          imem_addr    <= imem_addr + ADDR_W'(1);
          words_loaded <= words_loaded + CNT_W'(1);
        end
        CHK: begin
          if (accept_c) begin
            if (byte_in == acc) begin
              done     <= 1'b1;
              cpu_hold <= 1'b0;
            end else begin
              err      <= 1'b1;
              cpu_hold <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
